// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and helpers for the CORDIC sin/cos pipeline and its arbiter.
// Contents:
//   DEFAULT_STEP2_PHASE_BITS  step-2 phase width of the standard CORDIC build
//   cordic_latency()          CE-cycle latency of a CORDIC built with a given step-2 width
//   ch_bits()                 width of a channel index for a given channel count
package cordic_pkg;

    localparam int DEFAULT_STEP2_PHASE_BITS = 9;

    function automatic int cordic_latency(input int step2_bits);
        return 2 + step2_bits + 1;
    endfunction

    function automatic int ch_bits(input int num_channels);
        return $clog2(num_channels);
    endfunction

endpackage

// File: rtl/fixed_delay_shift_register.sv
// fixed_delay_shift_register: delays a data word by DELAY_CYCLES clock-enabled cycles.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset (clears every stage)
//   CE          clock enable; the line shifts only when high
//   DIN         word entering stage 0
//   DOUT        word leaving the last stage (DELAY_CYCLES CE-edges after entry)
module fixed_delay_shift_register #(
    parameter int DATA_BITS    = 8,
    parameter int DELAY_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CE,
    input  logic [DATA_BITS-1:0] DIN,
    output logic [DATA_BITS-1:0] DOUT
);

    logic [DELAY_CYCLES-1:0][DATA_BITS-1:0] sr;

    always_ff @(posedge CLK) begin
        if (RESET)
            sr <= '0;
        else if (CE)
            sr <= {sr[DELAY_CYCLES-2:0], DIN};
    end

    assign DOUT = sr[DELAY_CYCLES-1];

endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot round-robin grant with a registered last-winner pointer.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset (pointer to NUM_CHANNELS-1, so channel 0 wins first)
//   EN          grant enable; GRANT is zero and the pointer holds while low
//   REQ         per-channel request vector
//   GRANT       one-hot grant, searching upward from pointer+1 (combinational)
//   GRANT_IDX   index of the granted channel (0 when nothing is granted)
module round_robin_arbiter import cordic_pkg::*; #(
    parameter int NUM_CHANNELS = 4,
    localparam int CHB         = ch_bits(NUM_CHANNELS)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic [NUM_CHANNELS-1:0] REQ,
    output logic [NUM_CHANNELS-1:0] GRANT,
    output logic [CHB-1:0]          GRANT_IDX
);

    logic [CHB-1:0] ptr;
    logic [CHB-1:0] cand [NUM_CHANNELS];

    // cand[k] is the channel examined at search position k (priority falls with k)
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_cand
        assign cand[i] = CHB'((int'(ptr) + i + 1) % NUM_CHANNELS);
    end

    // Scan from lowest to highest priority so the highest-priority requester is written last
    always_comb begin
        GRANT     = '0;
        GRANT_IDX = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (EN && REQ[cand[k]]) begin
                GRANT     = NUM_CHANNELS'(1) << cand[k];
                GRANT_IDX = cand[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            ptr <= CHB'(NUM_CHANNELS - 1);
        else if (GRANT != '0)
            ptr <= GRANT_IDX;
    end

endmodule

// File: rtl/cordic_sin_cos_arbiter.sv
// cordic_sin_cos_arbiter: shares one cordic_sin_cos pipeline between NUM_CHANNELS requesters.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset (drops all in-flight results)
//   CE                  clock enable, shared with the CORDIC instance
//   REQ_VALID/PHASE     per-channel requests; channel i phase at [i*PHASE_BITS +: PHASE_BITS]
//   REQ_READY           one-hot round-robin grant (combinational, zero when RESET or !CE)
//   CORDIC_PHASE        registered phase to the CORDIC
//   CORDIC_SIN/COS      CORDIC results, LATENCY CE-cycles after CORDIC_PHASE
//   RES_VALID           one-hot result strobe, routed to the issuing channel
//   RES_CHANNEL/SIN/COS result channel index and values; hold between results
//   BUSY                any issue in flight or a result being presented
module cordic_sin_cos_arbiter import cordic_pkg::*; #(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_BITS   = 19,
    parameter int DATA_BITS    = 16,
    parameter int LATENCY      = cordic_latency(DEFAULT_STEP2_PHASE_BITS),
    localparam int CHB         = ch_bits(NUM_CHANNELS)
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               CE,
    input  logic [NUM_CHANNELS-1:0]            REQ_VALID,
    input  logic [NUM_CHANNELS*PHASE_BITS-1:0] REQ_PHASE,
    output logic [NUM_CHANNELS-1:0]            REQ_READY,
    output logic [PHASE_BITS-1:0]              CORDIC_PHASE,
    input  logic signed [DATA_BITS-1:0]        CORDIC_SIN,
    input  logic signed [DATA_BITS-1:0]        CORDIC_COS,
    output logic [NUM_CHANNELS-1:0]            RES_VALID,
    output logic [CHB-1:0]                     RES_CHANNEL,
    output logic signed [DATA_BITS-1:0]        RES_SIN,
    output logic signed [DATA_BITS-1:0]        RES_COS,
    output logic                               BUSY
);

    localparam int CNT_BITS = $clog2(LATENCY + 2);

    typedef struct packed {
        logic           valid;
        logic [CHB-1:0] ch;
    } tag_t;

    logic [NUM_CHANNELS-1:0] grant;
    logic [CHB-1:0]          grant_idx;
    logic [PHASE_BITS-1:0]   phase_arr [NUM_CHANNELS];
    tag_t                    tag_in;
    tag_t                    tag_out;
    logic [CNT_BITS-1:0]     inflight;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_phase
        assign phase_arr[i] = REQ_PHASE[i*PHASE_BITS +: PHASE_BITS];
    end

    round_robin_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (CE & ~RESET),
        .REQ       (REQ_VALID),
        .GRANT     (grant),
        .GRANT_IDX (grant_idx)
    );

    assign REQ_READY = grant;
    assign tag_in    = tag_t'{valid: |grant, ch: grant_idx};

    // One stage beyond the CORDIC latency: the tag enters with the phase register, so
    // the final stage lines up with CORDIC_SIN/COS for the output register to capture
    fixed_delay_shift_register #(
        .DATA_BITS    ($bits(tag_t)),
        .DELAY_CYCLES (LATENCY + 1)
    ) u_tags (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .DIN   (tag_in),
        .DOUT  (tag_out)
    );

    // inflight mirrors the number of valid tags in the delay line, giving BUSY without
    // tapping every stage
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CORDIC_PHASE <= '0;
            RES_VALID    <= '0;
            RES_CHANNEL  <= '0;
            RES_SIN      <= '0;
            RES_COS      <= '0;
            inflight     <= '0;
        end else if (CE) begin
            if (grant != '0)
                CORDIC_PHASE <= phase_arr[grant_idx];
            RES_VALID <= NUM_CHANNELS'(tag_out.valid) << tag_out.ch;
            if (tag_out.valid) begin
                RES_CHANNEL <= tag_out.ch;
                RES_SIN     <= CORDIC_SIN;
                RES_COS     <= CORDIC_COS;
            end
            inflight <= inflight + CNT_BITS'(|grant) - CNT_BITS'(tag_out.valid);
        end
    end

    assign BUSY = (inflight != '0) || (RES_VALID != '0);

endmodule

// File: tb/tb_cordic_sin_cos_arbiter.sv
// tb_cordic_sin_cos_arbiter: scoreboard bench for cordic_sin_cos_arbiter with a table-driven CORDIC stub.
module tb_cordic_sin_cos_arbiter;

    localparam int N   = 4;
    localparam int PB  = 19;
    localparam int DB  = 16;
    localparam int LAT = 12;

    // Stub CORDIC output per phase octant, a couple of LSBs off the ideal values
    localparam int STUB_SIN [8] = '{1, 23169, 32766, 23171, -1, -23169, -32766, -23171};
    localparam int STUB_COS [8] = '{32766, 23171, -1, -23169, -32766, -23171, 1, 23169};

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 CE = 1'b1;
    logic [N-1:0]         REQ_VALID = '0;
    logic [N*PB-1:0]      REQ_PHASE;
    logic [N-1:0]         REQ_READY;
    logic [PB-1:0]        CORDIC_PHASE;
    logic signed [DB-1:0] CORDIC_SIN;
    logic signed [DB-1:0] CORDIC_COS;
    logic [N-1:0]         RES_VALID;
    logic [1:0]           RES_CHANNEL;
    logic signed [DB-1:0] RES_SIN;
    logic signed [DB-1:0] RES_COS;
    logic                 BUSY;

    logic [PB-1:0] ph [N];
    logic [PB-1:0] cph [LAT];

    typedef struct {
        int ch;
        int s;
        int c;
        int due;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ce_cnt = 0;
    bit   ce_edge = 1'b0;
    int   last_ch = 0;
    int   last_s = 0;
    int   last_c = 0;

    always #5 CLK = ~CLK;

    assign REQ_PHASE = {ph[3], ph[2], ph[1], ph[0]};

    cordic_sin_cos_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CE           (CE),
        .REQ_VALID    (REQ_VALID),
        .REQ_PHASE    (REQ_PHASE),
        .REQ_READY    (REQ_READY),
        .CORDIC_PHASE (CORDIC_PHASE),
        .CORDIC_SIN   (CORDIC_SIN),
        .CORDIC_COS   (CORDIC_COS),
        .RES_VALID    (RES_VALID),
        .RES_CHANNEL  (RES_CHANNEL),
        .RES_SIN      (RES_SIN),
        .RES_COS      (RES_COS),
        .BUSY         (BUSY)
    );

    always @(posedge CLK) begin
        if (CE) begin
            cph[0] <= CORDIC_PHASE;
            for (int i = 1; i < LAT; i++)
                cph[i] <= cph[i-1];
        end
    end

    assign CORDIC_SIN = DB'(STUB_SIN[cph[LAT-1][18:16]]);
    assign CORDIC_COS = DB'(STUB_COS[cph[LAT-1][18:16]]);

    function automatic int exp_sin(input logic [PB-1:0] p);
        case (p[18:16])
            3'd0: return 0;
            3'd1: return 23170;
            3'd2: return 32767;
            3'd3: return 23170;
            3'd4: return 0;
            3'd5: return -23170;
            3'd6: return -32767;
            default: return -23170;
        endcase
    endfunction

    function automatic int exp_cos(input logic [PB-1:0] p);
        case (p[18:16])
            3'd0: return 32767;
            3'd1: return 23170;
            3'd2: return 0;
            3'd3: return -23170;
            3'd4: return -32767;
            3'd5: return -23170;
            3'd6: return 0;
            default: return 23170;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req, input int tol = 0);
        vectors++;
        if (act > req + tol || act < req - tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, req, tol, $time);
        end
    endtask

    always @(posedge CLK) begin
        ce_edge = CE && !RESET;
        if (ce_edge)
            ce_cnt++;
        if (RESET) begin
            last_ch = 0;
            last_s  = 0;
            last_c  = 0;
        end
    end

    always @(negedge CLK) begin
        if (ce_edge) begin
            if (RES_VALID != '0) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: RES_VALID=%b ch=%0d, expected no result", RES_VALID, RES_CHANNEL);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_valid_onehot", int'(RES_VALID), 1 << e.ch);
                    chk("res_channel", int'(RES_CHANNEL), e.ch);
                    chk("res_sin", int'(RES_SIN), e.s, 2);
                    chk("res_cos", int'(RES_COS), e.c, 2);
                    chk("res_latency_ce_edges", ce_cnt, e.due);
                    last_ch = e.ch;
                    last_s  = e.s;
                    last_c  = e.c;
                end
            end else begin
                chk("hold_channel", int'(RES_CHANNEL), last_ch);
                chk("hold_sin", int'(RES_SIN), last_s, 2);
                chk("hold_cos", int'(RES_COS), last_c, 2);
            end
        end
    end

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] rdy);
        REQ_VALID = v;
        @(negedge CLK);
        chk("req_ready", int'(REQ_READY), int'(rdy));
        for (int c = 0; c < N; c++)
            if (rdy[c])
                q.push_back('{c, exp_sin(ph[c]), exp_cos(ph[c]), ce_cnt + LAT + 2});
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        REQ_VALID = '0;
        for (int i = 0; i < 60 && q.size() > 0; i++)
            @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        chk("drain_outstanding", q.size(), 0);
        q.delete();
    endtask

    initial begin
        logic [N-1:0] rot [4];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int c = 0; c < N; c++)
            ph[c] = '0;
        REQ_VALID = '1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req_ready", int'(REQ_READY), 0);
        chk("reset_res_valid", int'(RES_VALID), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_cordic_phase", int'(CORDIC_PHASE), 0);
        chk("reset_res_sin", int'(RES_SIN), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        ph[0] = 19'h00000; ph[1] = 19'h10000; ph[2] = 19'h20000; ph[3] = 19'h30000;
        for (int k = 0; k < 8; k++)
            cycle('1, rot[k % 4]);
        drain();

        cycle(4'b0100, 4'b0100);
        chk("busy_inflight", int'(BUSY), 1);
        drain();
        chk("busy_idle", int'(BUSY), 0);

        ph[1] = 19'h7FFFF;
        cycle(4'b0010, 4'b0010);
        ph[1] = 19'h40000;
        cycle(4'b0010, 4'b0010);
        ph[1] = 19'h50000;
        cycle(4'b0010, 4'b0010);
        CE = 1'b0;
        REQ_VALID = '1;
        repeat (7) begin
            @(negedge CLK);
            chk("ce0_req_ready", int'(REQ_READY), 0);
            chk("ce0_busy", int'(BUSY), 1);
            chk("ce0_cordic_phase", int'(CORDIC_PHASE), 'h50000);
            @(posedge CLK);
            #1;
        end
        CE = 1'b1;
        drain();

        ph[0] = 19'h00000; ph[1] = 19'h10000; ph[2] = 19'h20000; ph[3] = 19'h30000;
        cycle('1, 4'b0100);
        cycle('1, 4'b1000);
        cycle('1, 4'b0001);
        cycle('1, 4'b0010);
        cycle('1, 4'b0100);
        RESET = 1'b1;
        q.delete();
        @(negedge CLK);
        chk("midreset_req_ready", int'(REQ_READY), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("midreset_res_valid", int'(RES_VALID), 0);
        chk("midreset_busy", int'(BUSY), 0);
        cycle('1, 4'b0001);
        drain();

        ph[0] = 19'h60000;
        ph[3] = 19'h30000;
        cycle(4'b0001, 4'b0001);
        cycle(4'b0001, 4'b0001);
        cycle(4'b1001, 4'b1000);
        cycle(4'b0001, 4'b0001);
        drain();

        for (int i = 0; i < 4; i++) begin
            ph[1] = PB'((2 * i + 1) << 16);
            cycle(4'b0010, 4'b0010);
            cycle(4'b0000, 4'b0000);
        end
        drain();

        repeat (5) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
